// File: rtl/xsp_decrypt_core.sv
// rtl/xsp_decrypt_core.sv - iterative XOR-Shift-Permutation decryptor, one inverse round per clock
// Accepts a ciphertext/key pair in IDLE, unrolls the forward rounds in reverse, presents plaintext in DONE.
module xsp_decrypt_core #(
  parameter int ROUNDS  = 4,
  parameter int KEY_ROT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] cipher_in,
  input  logic [7:0] key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] plain_out,
  output logic       busy
);

  localparam int CW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] round_cnt;
  logic [7:0]    data_q;
  logic [7:0]    key_q;
  logic [2:0]    key_amt;
  logic [7:0]    round_key;
  logic [7:0]    round_out;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} >> n;
    return t[7:0];
  endfunction

  // y[i] = x[(3*i) mod 8]; self-inverse, so the same wiring serves both directions
  function automatic logic [7:0] perm(input logic [7:0] x);
    return {x[5], x[2], x[7], x[4], x[1], x[6], x[3], x[0]};
  endfunction

  always_comb begin
    key_amt   = 3'(int'(round_cnt) * KEY_ROT);
    round_key = rotl8(key_q, key_amt);
    round_out = rotr8(perm(data_q), 3'd3) ^ round_key;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round_cnt <= '0;
      data_q    <= 8'h00;
      key_q     <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      plain_out <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q    <= cipher_in;
            key_q     <= key_in;
            round_cnt <= CW'(ROUNDS - 1);
            busy      <= 1'b1;
            state     <= ROUND;
          end
        end
        ROUND: begin
          data_q <= round_out;
          if (round_cnt == '0) begin
            plain_out <= round_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            round_cnt <= round_cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xsp_decrypt_core.sv
// tb/tb_xsp_decrypt_core.sv - scoreboard bench for xsp_decrypt_core (ROUNDS=1 and ROUNDS=4 instances)
// Slot 0 is the single-round core, slot 1 the four-round core; outputs are sampled on the falling edge.
module tb_xsp_decrypt_core;

  logic       clk;
  logic       rst;
  logic       in_valid_a  [2];
  logic       in_ready_a  [2];
  logic [7:0] cipher_a    [2];
  logic [7:0] key_a       [2];
  logic       out_valid_a [2];
  logic       out_ready_a [2];
  logic [7:0] plain_a     [2];
  logic       busy_a      [2];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  xsp_decrypt_core #(.ROUNDS(1), .KEY_ROT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .cipher_in(cipher_a[0]), .key_in(key_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .plain_out(plain_a[0]), .busy(busy_a[0])
  );

  xsp_decrypt_core #(.ROUNDS(4), .KEY_ROT(1)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .cipher_in(cipher_a[1]), .key_in(key_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .plain_out(plain_a[1]), .busy(busy_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    int m;
    m = n % 8;
    return 8'((x << m) | (x >> (8 - m)));
  endfunction

  function automatic logic [7:0] fwd_perm(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = x[(3 * i) % 8];
    return y;
  endfunction

  function automatic logic [7:0] encrypt(input logic [7:0] d, input logic [7:0] k, input int rounds);
    logic [7:0] x;
    x = d;
    for (int r = 0; r < rounds; r++) begin
      x = x ^ rotl(k, r);
      x = rotl(x, 3);
      x = fwd_perm(x);
    end
    return x;
  endfunction

  // returns on the falling edge just after the accept edge, in_valid already dropped
  task automatic start(input int d, input logic [7:0] c, input logic [7:0] k, input logic [7:0] e);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready_a[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a[d]) check("in_ready_timeout", 32'(in_ready_a[d]), 32'd1);
    cipher_a[d]   = c;
    key_a[d]      = k;
    in_valid_a[d] = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid_a[d] = 1'b0;
  endtask

  task automatic finish(input int d, input string tag, input int exp_lat, output logic [7:0] want);
    int n;
    n = 0;
    while (!out_valid_a[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, 32'(out_valid_a[d]), 32'd1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_plain"}, 32'(plain_a[d]), 32'(want));
    if (exp_lat > 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  logic [7:0] pair_d [10] = '{8'hCC, 8'hF0, 8'hAA, 8'h0F, 8'h55, 8'h33, 8'hC3, 8'h78, 8'hA5, 8'hFF};
  logic [7:0] pair_k [10] = '{8'hAA, 8'h0F, 8'h55, 8'hF0, 8'hAA, 8'hCC, 8'h3C, 8'h87, 8'h5A, 8'h00};

  initial begin
    logic [7:0] got;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d]  = 1'b0;
      cipher_a[d]    = 8'h00;
      key_a[d]       = 8'h00;
      out_ready_a[d] = 1'b1;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", 32'(in_ready_a[d]), 32'd1);
      check("rst_out_valid", 32'(out_valid_a[d]), 32'd0);
      check("rst_busy", 32'(busy_a[d]), 32'd0);
      check("rst_plain", 32'(plain_a[d]), 32'h00);
    end
    @(negedge clk);
    rst = 1'b0;

    // single round: pure permute/rotate, then pure key XOR
    start(0, 8'h01, 8'h00, 8'h20);
    finish(0, "r1_perm", 1, got);
    start(0, 8'h00, 8'hA5, 8'hA5);
    finish(0, "r1_key", 1, got);

    // four rounds with zero key is the identity
    start(1, 8'hC3, 8'h00, 8'hC3);
    finish(1, "r4_identity", 4, got);

    for (int i = 0; i < 10; i++) begin
      start(1, encrypt(pair_d[i], pair_k[i], 4), pair_k[i], pair_d[i]);
      finish(1, $sformatf("rt4_%0d", i), 4, got);
      start(0, encrypt(pair_d[i], pair_k[i], 1), pair_k[i], pair_d[i]);
      finish(0, $sformatf("rt1_%0d", i), 1, got);
    end

    // backpressure in DONE
    out_ready_a[1] = 1'b0;
    start(1, encrypt(8'h5C, 8'h93, 4), 8'h93, 8'h5C);
    finish(1, "bp", 4, got);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_plain", 32'(plain_a[1]), 32'h5C);
      check("bp_hold_valid", 32'(out_valid_a[1]), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready_a[1]), 32'd0);
    end
    out_ready_a[1] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid_a[1]), 32'd0);
    check("bp_release_in_ready", 32'(in_ready_a[1]), 32'd1);

    // input churn while rounds are in flight
    start(1, encrypt(8'h3E, 8'hD1, 4), 8'hD1, 8'h3E);
    in_valid_a[1] = 1'b1;
    cipher_a[1]   = 8'hFF;
    key_a[1]      = 8'h77;
    @(negedge clk);
    cipher_a[1]   = 8'h12;
    key_a[1]      = 8'hEE;
    check("churn_in_ready", 32'(in_ready_a[1]), 32'd0);
    @(negedge clk);
    in_valid_a[1] = 1'b0;
    finish(1, "churn", 0, got);
    @(negedge clk);
    check("churn_no_second_busy", 32'(busy_a[1]), 32'd0);
    check("churn_no_second_ready", 32'(in_ready_a[1]), 32'd1);

    // asynchronous reset in the middle of ROUND
    @(negedge clk);
    cipher_a[1]   = 8'h9A;
    key_a[1]      = 8'h4B;
    in_valid_a[1] = 1'b1;
    @(negedge clk);
    in_valid_a[1] = 1'b0;
    check("mid_busy", 32'(busy_a[1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_busy", 32'(busy_a[1]), 32'd0);
    check("async_in_ready", 32'(in_ready_a[1]), 32'd1);
    check("async_out_valid", 32'(out_valid_a[1]), 32'd0);
    check("async_plain", 32'(plain_a[1]), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready_a[1]), 32'd1);
    check("post_rst_out_valid", 32'(out_valid_a[1]), 32'd0);

    start(1, encrypt(8'h81, 8'h6D, 4), 8'h6D, 8'h81);
    finish(1, "post_rst_block", 4, got);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
